// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB host definitions: out_trans states, retry/timeout defaults, PIDs
package usb_pkg;

    localparam int TIMEOUT_CYCLES = 255;
    localparam int MAX_RETRY      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SEND_OUT,
        ST_WAIT_SEND_DATA,
        ST_WAIT_RESPONSE
    } out_state_e;

    // 4-bit PID codes shared with PH_Sender and PH_Receiver
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

endpackage

// File: rtl/resp_timer.sv
// rtl/resp_timer.sv - clearable, enabled response up-counter with terminal-count flag
module resp_timer #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_term = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/out_trans.sv
// rtl/out_trans.sv - host OUT transaction engine: OUT token + DATA0, handshake wait, NAK/timeout retry
module out_trans
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES,
    parameter int MAX_RETRY_P      = MAX_RETRY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        sending,
    output logic        done,
    output logic        success,
    output logic        failure,
    output logic        send_OUT,
    output logic        send_DATA0,
    output logic [63:0] data_out,
    input  logic        sent,
    input  logic        rec_ACK,
    input  logic        rec_NAK,
    input  logic        rec_start
);

    localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);

    out_state_e  r_state;
    out_state_e  w_next;
    logic [63:0] r_data;
    logic [3:0]  r_nak_cnt;
    logic [3:0]  r_to_cnt;

    logic w_load;
    logic w_clr_cnt;
    logic w_nak_inc;
    logic w_to_inc;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_tmr_term;
    logic w_nak_last;
    logic w_to_last;

    assign w_nak_last = (r_nak_cnt == 4'(MAX_RETRY_P - 1));
    assign w_to_last  = (r_to_cnt  == 4'(MAX_RETRY_P - 1));
    assign data_out   = r_data;

    resp_timer #(
        .WIDTH    (TW),
        .TERMINAL (TIMEOUT_CYCLES_P)
    ) u_resp_timer (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (w_tmr_en),
        .o_term (w_tmr_term)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_nak_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_data <= data_in;
            end
            if (w_clr_cnt) begin
                r_nak_cnt <= '0;
                r_to_cnt  <= '0;
            end else begin
                if (w_nak_inc) r_nak_cnt <= r_nak_cnt + 4'd1;
                if (w_to_inc)  r_to_cnt  <= r_to_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        sending    = 1'b0;
        done       = 1'b0;
        success    = 1'b0;
        failure    = 1'b0;
        send_OUT   = 1'b0;
        send_DATA0 = 1'b0;
        w_load     = 1'b0;
        w_clr_cnt  = 1'b0;
        w_nak_inc  = 1'b0;
        w_to_inc   = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_en   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    send_OUT  = 1'b1;
                    w_load    = 1'b1;
                    w_clr_cnt = 1'b1;
                    w_next    = ST_WAIT_SEND_OUT;
                end
            end
            ST_WAIT_SEND_OUT: begin
                if (sent) begin
                    send_DATA0 = 1'b1;
                    w_next     = ST_WAIT_SEND_DATA;
                end else begin
                    sending = 1'b1;
                end
            end
            ST_WAIT_SEND_DATA: begin
                if (sent) begin
                    w_tmr_clr = 1'b1;
                    w_next    = ST_WAIT_RESPONSE;
                end else begin
                    sending = 1'b1;
                end
            end
            ST_WAIT_RESPONSE: begin
                // ACK outranks everything, including a coincident timeout
                if (rec_ACK) begin
                    done    = 1'b1;
                    success = 1'b1;
                    w_next  = ST_IDLE;
                end else if (rec_NAK) begin
                    if (w_nak_last) begin
                        done    = 1'b1;
                        failure = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_nak_inc = 1'b1;
                        send_OUT  = 1'b1;
                        w_next    = ST_WAIT_SEND_OUT;
                    end
                end else if (rec_start) begin
                    w_tmr_clr = 1'b1;
                end else if (w_tmr_term) begin
                    if (w_to_last) begin
                        done    = 1'b1;
                        failure = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_to_inc = 1'b1;
                        send_OUT = 1'b1;
                        w_next   = ST_WAIT_SEND_OUT;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
